orv64_ptw_cache_arb: RTL and testbench
======================================

# orv64_ptw_cache_arb

Merges the three per-source page-table-walker cache ports (ITLB, DTLB, VTLB walkers, indices `ORV64_IPTW_SRC_ID`/`ORV64_DPTW_SRC_ID`/`ORV64_VPTW_SRC_ID`) onto one `cpu_cache_if` port toward the L1 data cache. It sits directly downstream of `orv64_ptw` and directly upstream of the D-cache PTW port. The block uses round-robin request arbitration. An in-order source-ID FIFO routes each cache response back to the walker that issued the request.

## Interface
Parameters:
- `N_OUTSTANDING`, default 4: maximum requests in flight to the cache; sets the depth of the source-ID FIFO. Must be at least 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ptw_req_valid`  in  [2:0]  request valid, one bit per walker.
- `ptw_req`  in  `cpu_cache_if_req_t [2:0]`  walker requests.
- `ptw_req_ready`  out  [2:0]  request accepted, per walker.
- `ptw_resp_valid`  out  [2:0]  response valid, per walker.
- `ptw_resp`  out  `cpu_cache_if_resp_t [2:0]`  walker responses.
- `ptw_resp_ready`  in  [2:0]  walker can take a response.
- `dc_req_valid`  out  1  merged request valid.
- `dc_req`  out  `cpu_cache_if_req_t`  merged request.
- `dc_req_ready`  in  1  cache accepts the request.
- `dc_resp_valid`  in  1  cache response valid.
- `dc_resp`  in  `cpu_cache_if_resp_t`  cache response.
- `dc_resp_ready`  out  1  arbiter accepts the response.

## Operation
- State:
  - `rr_ptr` (2 bits, values 0–2): highest-priority port.
  - `lock_vld` and `lock_port`: hold a grant that has been presented but not yet accepted.
  - Source-ID FIFO: `N_OUTSTANDING` entries × 2 bits, with read and write pointers and an occupancy count `cnt` of width $clog2(N_OUTSTANDING+1).
- Issue enable: `can_issue = (cnt != N_OUTSTANDING)`.
  - A pop in the same cycle does not free a slot for a push. This keeps the ready path independent of the response path.
- Grant selection:
  - If `lock_vld`, the grant is `lock_port`.
  - Otherwise the grant is the first port with `ptw_req_valid` set, searching in the order `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` (mod 3).
- `dc_req_valid = can_issue & any_grant`. `dc_req` is the granted port's `ptw_req`. When `dc_req_valid` is 0, `dc_req` is all zeros.
- `ptw_req_ready[g] = can_issue & dc_req_ready`, for the granted port `g` only. All other bits are 0.
- On a request handshake on port `g`:
  - push `g` into the FIFO;
  - set `rr_ptr` to `(g+1) mod 3`;
  - clear `lock_vld`.
- When `dc_req_valid & ~dc_req_ready`: set `lock_vld` and `lock_port = g`. The same port stays granted until its handshake, so valid/request stability holds toward the cache.
- Response routing uses `h`, the FIFO head, and requires the FIFO to be non-empty:
  - `ptw_resp_valid[h] = dc_resp_valid`;
  - `ptw_resp[h] = dc_resp`, while the other ports see zeros;
  - `dc_resp_ready = ptw_resp_ready[h]`.
- On a response handshake, pop the FIFO.
- When the FIFO is empty: `dc_resp_ready = 0` and `ptw_resp_valid = 0`. A `dc_resp_valid` in this state is a protocol error and is flagged by a simulation assertion.
- Simultaneous push and pop with `0 < cnt < N_OUTSTANDING`: `cnt` is unchanged and both pointers advance. Pointers wrap modulo `N_OUTSTANDING`.
- The cache must return responses in request order. This block does not reorder.

## Timing
- Request path: zero latency, combinational from `ptw_req_valid` to `dc_req_valid`.
- Response path: zero latency, combinational from `dc_resp_valid` to `ptw_resp_valid`.
- One request and one response may complete per cycle.
- Reset values:
  - `rr_ptr = 0`, `lock_vld = 0`, FIFO empty (`cnt = 0`, pointers 0).
  - Outputs: `dc_req_valid = 0`, `ptw_req_ready = 0`, `ptw_resp_valid = 0`, `dc_resp_valid`-independent `dc_resp_ready = 0`, `dc_req` and `ptw_resp` all zeros.
- Reset asserted mid-operation discards all in-flight tracking. The walkers and the cache are reset in the same domain.
- Fairness: a port that holds `ptw_req_valid` is granted within 3 request handshakes.

## Test plan
- **Single request:** port 1 requests with `rr_ptr = 0`, `dc_req_ready = 1`.
  - `dc_req` equals `ptw_req[1]` in the same cycle and `ptw_req_ready = 3'b010`.
  - Next cycle `rr_ptr = 2` and `cnt = 1`.
  - A later `dc_resp_valid` appears only on `ptw_resp_valid[1]`.
- **Round robin:** all 3 ports hold valid and `dc_req_ready = 1` constantly.
  - Grant order is 0, 1, 2, 0, 1, 2; `ptw_req_ready` is 001, 010, 100, repeating.
- **Lock:** port 2 is granted with `dc_req_ready = 0` for 3 cycles; port 0 raises valid in cycle 2.
  - `dc_req` stays equal to `ptw_req[2]` throughout.
  - Port 2 handshakes in cycle 4, then port 0 is granted.
- **Full:** with `N_OUTSTANDING = 4`, issue 4 requests with no responses.
  - In the 5th cycle, `dc_req_valid = 0` and `ptw_req_ready = 0`.
  - In the cycle a response pops, issue is still blocked; the next cycle the request issues.
- **Ordered routing:** issue from ports 2, 0, 2, 1, then return 4 responses.
  - They route to ports 2, 0, 2, 1.
  - With `ptw_resp_ready[0] = 0` for 2 cycles at the 2nd response, `dc_resp_ready = 0` for those cycles and the FIFO head does not change.
- **Mid-flight reset:** assert `rst` with `cnt = 3` and `lock_vld = 1`.
  - All outputs are at their reset values immediately (asynchronously).
  - After release, a port 0 request is granted first.

Source files
------------

// File: rtl/orv64_ptw_cache_arb.sv
// orv64_ptw_cache_arb
// Merges the ITLB/DTLB/VTLB page-table-walker cache ports onto the single
// D-cache PTW port. Requests are arbitrated round-robin. A grant that was
// presented but not yet accepted is held, so the request stays stable toward
// the cache. A FIFO of source IDs routes the in-order cache responses back to
// the walker that issued each request.
//
// Parameters:
//   N_OUTSTANDING  max requests in flight (source-ID FIFO depth), >= 1
//   REQ_W / RESP_W width of the flattened cpu_cache_if request/response
// Ports:
//   clk, rst                       clock, async active-high reset
//   ptw_req_valid/ptw_req/ready    per-walker request channel (3 walkers)
//   ptw_resp_valid/ptw_resp/ready  per-walker response channel
//   dc_req_valid/dc_req/ready      merged request toward the D-cache
//   dc_resp_valid/dc_resp/ready    response from the D-cache
module orv64_ptw_cache_arb #(
    parameter int unsigned N_OUTSTANDING = 4,
    parameter int unsigned REQ_W         = 64,
    parameter int unsigned RESP_W        = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             ptw_req_valid,
    input  logic [2:0][REQ_W-1:0]  ptw_req,
    output logic [2:0]             ptw_req_ready,
    output logic [2:0]             ptw_resp_valid,
    output logic [2:0][RESP_W-1:0] ptw_resp,
    input  logic [2:0]             ptw_resp_ready,
    output logic                   dc_req_valid,
    output logic [REQ_W-1:0]       dc_req,
    input  logic                   dc_req_ready,
    input  logic                   dc_resp_valid,
    input  logic [RESP_W-1:0]      dc_resp,
    output logic                   dc_resp_ready
);

    localparam int unsigned PTR_W = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(N_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_OUTSTANDING - 1);

    logic [1:0]       rr_q, rr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [1:0]       lock_port_q, lock_port_d;
    logic [1:0]       fifo_q [N_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       can_issue, any_grant, push, pop, fifo_empty;
    logic [1:0] gnt, head;

    function automatic logic [1:0] add_mod3(logic [1:0] a, logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle never frees a slot, keeping ready off the response path.
    assign can_issue  = (cnt_q != FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Grant: held port while locked, else first valid port starting at rr_q.
    always_comb begin
        gnt       = rr_q;
        any_grant = 1'b0;
        if (lock_vld_q) begin
            gnt       = lock_port_q;
            any_grant = ptw_req_valid[lock_port_q];
        end else begin
            // Descending scan so the lowest offset from rr_q wins.
            for (int k = 2; k >= 0; k--) begin
                if (ptw_req_valid[add_mod3(rr_q, 2'(k))]) begin
                    gnt       = add_mod3(rr_q, 2'(k));
                    any_grant = 1'b1;
                end
            end
        end
    end

    // Request path; rst gating keeps outputs at reset values while rst is high.
    always_comb begin
        dc_req_valid  = ~rst & can_issue & any_grant;
        dc_req        = dc_req_valid ? ptw_req[gnt] : '0;
        ptw_req_ready = '0;
        if (dc_req_valid && dc_req_ready) ptw_req_ready[gnt] = 1'b1;
    end

    // Response path: only the walker at the FIFO head sees the cache response.
    always_comb begin
        ptw_resp_valid = '0;
        ptw_resp       = '0;
        dc_resp_ready  = 1'b0;
        if (!rst && !fifo_empty) begin
            ptw_resp_valid[head] = dc_resp_valid;
            ptw_resp[head]       = dc_resp;
            dc_resp_ready        = ptw_resp_ready[head];
        end
    end

    assign push = dc_req_valid & dc_req_ready;
    assign pop  = dc_resp_valid & dc_resp_ready;

    always_comb begin
        rr_d        = push ? add_mod3(gnt, 2'd1) : rr_q;
        // Lock only while a presented request waits; a handshake releases it.
        lock_vld_d  = dc_req_valid & ~dc_req_ready;
        lock_port_d = lock_vld_d ? gnt : lock_port_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d       = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= 2'd0;
            lock_vld_q  <= 1'b0;
            lock_port_q <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(N_OUTSTANDING); i++) fifo_q[i] <= 2'd0;
        end else begin
            rr_q        <= rr_d;
            lock_vld_q  <= lock_vld_d;
            lock_port_q <= lock_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            if (push) fifo_q[wr_ptr_q] <= gnt;
        end
    end

`ifndef SYNTHESIS
    // A cache response with nothing outstanding cannot be routed.
    resp_without_req: assert property (@(posedge clk) disable iff (rst)
        !(dc_resp_valid && fifo_empty))
        else $error("dc_resp_valid with no outstanding request");
`endif

endmodule

// File: tb/tb_orv64_ptw_cache_arb.sv
module tb_orv64_ptw_cache_arb;
    localparam int N  = 4;
    localparam int RW = 16;
    localparam int SW = 16;

    logic               clk;
    logic               rst;
    logic [2:0]         ptw_req_valid;
    logic [2:0][RW-1:0] ptw_req;
    logic [2:0]         ptw_req_ready;
    logic [2:0]         ptw_resp_valid;
    logic [2:0][SW-1:0] ptw_resp;
    logic [2:0]         ptw_resp_ready;
    logic               dc_req_valid;
    logic [RW-1:0]      dc_req;
    logic               dc_req_ready;
    logic               dc_resp_valid;
    logic [SW-1:0]      dc_resp;
    logic               dc_resp_ready;

    orv64_ptw_cache_arb #(
        .N_OUTSTANDING(N),
        .REQ_W        (RW),
        .RESP_W       (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ptw_req_valid (ptw_req_valid),
        .ptw_req       (ptw_req),
        .ptw_req_ready (ptw_req_ready),
        .ptw_resp_valid(ptw_resp_valid),
        .ptw_resp      (ptw_resp),
        .ptw_resp_ready(ptw_resp_ready),
        .dc_req_valid  (dc_req_valid),
        .dc_req        (dc_req),
        .dc_req_ready  (dc_req_ready),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp       (dc_resp),
        .dc_resp_ready (dc_resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] rv;
        logic       drdy;
        logic       rspv;
        logic [2:0] rsprdy;
        logic       e_dv;
        int         e_g;
        logic [2:0] e_rdy;
        logic [2:0] e_rspv;
        logic       e_drr;
    } vec_t;

    function automatic logic [RW-1:0] pat(int p);
        return RW'(16'hA0F0 + p * 16'h0111);
    endfunction

    task automatic cmp(string name, logic [2:0] e_rdy, logic e_dv, logic [RW-1:0] e_req,
                       logic [2:0] e_rspv, logic [2:0][SW-1:0] e_rsp, logic e_drr);
        vectors++;
        if (ptw_req_ready !== e_rdy || dc_req_valid !== e_dv || dc_req !== e_req ||
            ptw_resp_valid !== e_rspv || ptw_resp !== e_rsp || dc_resp_ready !== e_drr) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b dv=%b req=%h rspv=%b rsp=%h drr=%b want rdy=%b dv=%b req=%h rspv=%b rsp=%h drr=%b",
                     name, ptw_req_ready, dc_req_valid, dc_req, ptw_resp_valid, ptw_resp,
                     dc_resp_ready, e_rdy, e_dv, e_req, e_rspv, e_rsp, e_drr);
        end
    endtask

    task automatic clear_inputs();
        ptw_req_valid  = '0;
        ptw_req        = '0;
        ptw_resp_ready = '0;
        dc_req_ready   = 1'b0;
        dc_resp_valid  = 1'b0;
        dc_resp        = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    initial begin : main
        vec_t               tbl[20];
        logic [2:0][SW-1:0] e_rsp;
        int                 q[$];
        int                 rr, lock, g, h, p;
        logic               any, can, e_dv, e_drr;
        logic [2:0]         e_rdy, e_rspv, pend;
        logic [RW-1:0]      e_req;

        // Reset state, with busy inputs to show the outputs are held.
        rst = 1'b1;
        clear_inputs();
        ptw_req_valid  = 3'b111;
        ptw_req        = {pat(2), pat(1), pat(0)};
        dc_req_ready   = 1'b1;
        dc_resp_valid  = 1'b1;
        ptw_resp_ready = 3'b111;
        dc_resp        = 16'h1234;
        #3;
        cmp("reset", 3'b000, 1'b0, '0, 3'b000, '0, 1'b0);
        clear_inputs();
        #3;
        rst = 1'b0;
        tick();

        //           rv      drdy  rspv  rsprdy  dv    g  rdy     rspv    drr
        tbl[0]  = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 0, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{3'b010, 1'b1, 1'b0, 3'b000, 1'b1, 1, 3'b010, 3'b000, 1'b0};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 2, 3'b100, 3'b000, 1'b0};
        tbl[3]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 0, 3'b001, 3'b000, 1'b0};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 1, 3'b010, 3'b000, 1'b0};
        tbl[5]  = '{3'b111, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b010, 1'b1};
        tbl[6]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 2, 3'b100, 3'b000, 1'b0};
        tbl[7]  = '{3'b000, 1'b1, 1'b1, 3'b011, 1'b0, 0, 3'b000, 3'b100, 1'b0};
        tbl[8]  = '{3'b000, 1'b1, 1'b1, 3'b011, 1'b0, 0, 3'b000, 3'b100, 1'b0};
        tbl[9]  = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b100, 1'b1};
        tbl[10] = '{3'b100, 1'b0, 1'b0, 3'b000, 1'b1, 2, 3'b000, 3'b000, 1'b0};
        tbl[11] = '{3'b101, 1'b0, 1'b0, 3'b000, 1'b1, 2, 3'b000, 3'b000, 1'b0};
        tbl[12] = '{3'b101, 1'b0, 1'b0, 3'b000, 1'b1, 2, 3'b000, 3'b000, 1'b0};
        tbl[13] = '{3'b101, 1'b1, 1'b1, 3'b111, 1'b1, 2, 3'b100, 3'b001, 1'b1};
        tbl[14] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b1, 0, 3'b001, 3'b000, 1'b0};
        tbl[15] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b010, 1'b1};
        tbl[16] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b100, 1'b1};
        tbl[17] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b100, 1'b1};
        tbl[18] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 0, 3'b000, 3'b001, 1'b1};
        tbl[19] = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 0, 3'b000, 3'b000, 1'b0};

        for (int i = 0; i < 20; i++) begin
            ptw_req_valid  = tbl[i].rv;
            ptw_req        = {pat(2), pat(1), pat(0)};
            dc_req_ready   = tbl[i].drdy;
            dc_resp_valid  = tbl[i].rspv;
            ptw_resp_ready = tbl[i].rsprdy;
            dc_resp        = tbl[i].rspv ? SW'(16'hC000 + i) : '0;
            for (int k = 0; k < 3; k++) e_rsp[k] = tbl[i].e_rspv[k] ? dc_resp : '0;
            #4;
            cmp($sformatf("table[%0d]", i), tbl[i].e_rdy, tbl[i].e_dv,
                tbl[i].e_dv ? pat(tbl[i].e_g) : '0, tbl[i].e_rspv, e_rsp, tbl[i].e_drr);
            tick();
        end

        // Mid-flight reset with three outstanding and a held grant on port 1.
        reset_dut();
        ptw_req       = {pat(2), pat(1), pat(0)};
        ptw_req_valid = 3'b111;
        dc_req_ready  = 1'b1;
        #4 cmp("mf_g0", 3'b001, 1'b1, pat(0), 3'b000, '0, 1'b0);
        tick();
        #4 cmp("mf_g1", 3'b010, 1'b1, pat(1), 3'b000, '0, 1'b0);
        tick();
        #4 cmp("mf_g2", 3'b100, 1'b1, pat(2), 3'b000, '0, 1'b0);
        tick();
        ptw_req_valid = 3'b110;
        dc_req_ready  = 1'b0;
        #4 cmp("mf_lock", 3'b000, 1'b1, pat(1), 3'b000, '0, 1'b0);
        tick();
        #1;
        rst            = 1'b1;
        dc_req_ready   = 1'b1;
        dc_resp_valid  = 1'b1;
        ptw_resp_ready = 3'b111;
        dc_resp        = 16'h5555;
        #1 cmp("mf_in_reset", 3'b000, 1'b0, '0, 3'b000, '0, 1'b0);
        dc_resp_valid = 1'b0;
        ptw_req_valid = 3'b111;
        #1 rst = 1'b0;
        #1 cmp("mf_after", 3'b001, 1'b1, pat(0), 3'b000, '0, 1'b0);
        tick();

        // Randomised traffic against a queue-based model.
        reset_dut();
        q.delete();
        rr   = 0;
        lock = -1;
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ptw_req_valid = pend | 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            for (int k = 0; k < 3; k++) if (!pend[k]) ptw_req[k] = RW'($urandom);
            dc_req_ready   = ($urandom_range(0, 3) != 0);
            dc_resp_valid  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            ptw_resp_ready = 3'($urandom_range(1, 7));
            dc_resp        = SW'($urandom);

            can = (q.size() != N);
            any = 1'b0;
            g   = 0;
            if (lock >= 0) begin
                g   = lock;
                any = ptw_req_valid[lock];
            end else begin
                for (int k = 0; k < 3; k++) begin
                    p = (rr + k) % 3;
                    if (!any && ptw_req_valid[p]) begin
                        g   = p;
                        any = 1'b1;
                    end
                end
            end
            e_dv   = can && any;
            e_req  = e_dv ? ptw_req[g] : '0;
            e_rdy  = (e_dv && dc_req_ready) ? 3'(1 << g) : 3'b000;
            e_rspv = '0;
            e_rsp  = '0;
            e_drr  = 1'b0;
            if (q.size() > 0) begin
                h         = q[0];
                e_rspv[h] = dc_resp_valid;
                e_rsp[h]  = dc_resp;
                e_drr     = ptw_resp_ready[h];
            end
            #4 cmp($sformatf("rand[%0d]", cyc), e_rdy, e_dv, e_req, e_rspv, e_rsp, e_drr);

            if (dc_resp_valid && e_drr) void'(q.pop_front());
            if (e_dv && dc_req_ready) begin
                q.push_back(g);
                rr   = (g + 1) % 3;
                lock = -1;
            end else if (e_dv) begin
                lock = g;
            end else begin
                lock = -1;
            end
            pend = ptw_req_valid & ~e_rdy;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
